// File: rtl/t_inst_wide_ser.sv
// Wide-word to narrow-beat serializer: one packed word in, NBEATS beats out, LSB beat first.
// Optional macro T_WIDE_SER_PARITY_EN appends an XOR parity beat to every word.
module t_inst_wide_ser #(
    parameter int WIDTH = 104,
    parameter int BEAT  = 8
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [BEAT-1:0]  o_beat,
    output logic             o_first,
    output logic             o_last,
    output logic             o_busy
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both high;
    // valid never waits for ready, and o_beat/o_first/o_last stay stable while o_ready is low.

    localparam int NBEATS = (WIDTH + BEAT - 1) / BEAT;
`ifdef T_WIDE_SER_PARITY_EN
    localparam int NTOTAL = NBEATS + 1;
`else
    localparam int NTOTAL = NBEATS;
`endif
    localparam int PW = NBEATS * BEAT;
    localparam int SW = NTOTAL * BEAT;
    localparam int CW = (NTOTAL > 1) ? $clog2(NTOTAL) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NTOTAL - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   sh_q, sh_d;
    logic [PW-1:0]   word_pad;
    logic [SW-1:0]   load_val;
    logic            accept;

    // Pad bits above WIDTH are zero so a short final beat is zero-filled.
    always_comb begin
        word_pad = PW'(i_data);
    end

`ifdef T_WIDE_SER_PARITY_EN
    logic [BEAT-1:0] par;
    always_comb begin
        par = '0;
        for (int k = 0; k < NBEATS; k++) begin
            par = par ^ word_pad[k*BEAT +: BEAT];
        end
        load_val = {par, word_pad};
    end
`else
    always_comb begin
        load_val = word_pad;
    end
`endif

    assign o_valid = (state_q == SEND);
    assign o_busy  = (state_q == SEND);
    assign o_beat  = sh_q[BEAT-1:0];
    assign o_first = (state_q == SEND) && (cnt_q == '0);
    assign o_last  = (state_q == SEND) && (cnt_q == LAST_IDX);
    // Accepting on the last-beat transfer lets back-to-back words run with no idle cycle.
    assign i_ready = (state_q == IDLE) | (o_last & o_ready);
    assign accept  = i_valid & i_ready;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        if (accept) begin
            state_d = SEND;
            cnt_d   = '0;
            sh_d    = load_val;
        end else if ((state_q == SEND) && o_ready) begin
            if (o_last) begin
                state_d = IDLE;
                cnt_d   = '0;
                sh_d    = '0;
            end else begin
                sh_d  = sh_q >> BEAT;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_t_inst_wide_ser.sv
// Self-checking bench for t_inst_wide_ser: vector table plus hand-written multi-cycle sequences.
// Honours T_WIDE_SER_PARITY_EN when the build defines it.
module tb_t_inst_wide_ser;

`ifdef T_WIDE_SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NT = 13 + PAR;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_l = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- main DUT (104/8) ----------------
    logic         i_valid = 1'b0;
    logic         i_ready;
    logic [103:0] i_data = '0;
    logic         o_valid;
    logic         o_ready = 1'b0;
    logic [7:0]   o_beat;
    logic         o_first, o_last, o_busy;

    t_inst_wide_ser #(.WIDTH(104), .BEAT(8)) u_dut (
        .clk(clk), .reset_l(reset_l),
        .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
        .o_valid(o_valid), .o_ready(o_ready), .o_beat(o_beat),
        .o_first(o_first), .o_last(o_last), .o_busy(o_busy)
    );

    // ---------------- padding DUT (105/8) ----------------
    logic         p_valid = 1'b0;
    logic         p_iready;
    logic [104:0] p_data = '0;
    logic         p_ovalid;
    logic         p_oready = 1'b1;
    logic [7:0]   p_beat;
    logic         p_first, p_last, p_busy;

    t_inst_wide_ser #(.WIDTH(105), .BEAT(8)) u_pad (
        .clk(clk), .reset_l(reset_l),
        .i_valid(p_valid), .i_ready(p_iready), .i_data(p_data),
        .o_valid(p_ovalid), .o_ready(p_oready), .o_beat(p_beat),
        .o_first(p_first), .o_last(p_last), .o_busy(p_busy)
    );

    // ---------------- scoreboard ----------------
    logic [9:0] exp_q[$];
    logic [9:0] pq[$];
    int tests = 0;
    int fails = 0;
    int xfer_cnt = 0;
    int p_xfer = 0;
    int first_cyc = 0;
    int last_cyc = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entry layout {first, last, beat}; model computes beats straight from the word.
    task automatic push_exp(input logic [127:0] d, input int w, input int sel);
        int nb, nt;
        logic [7:0] b, par;
        logic [127:0] m;
        logic [9:0] e;
        m = d & ((128'd1 << w) - 128'd1);
        nb = (w + 7) / 8;
        nt = nb + PAR;
        par = 8'h00;
        for (int i = 0; i < nt; i++) begin
            b = (i < nb) ? m[i*8 +: 8] : par;
            if (i < nb) par = par ^ b;
            e = {(i == 0), (i == nt - 1), b};
            if (sel == 0) exp_q.push_back(e);
            else pq.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (reset_l && o_valid) begin
            if (exp_q.size() == 0) begin
                if (o_ready) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got %0h expected none", o_beat);
                end
            end else begin
                check(o_ready ? "beat" : "held_beat", {o_first, o_last, o_beat}, exp_q[0]);
                if (o_ready) begin
                    void'(exp_q.pop_front());
                    if (xfer_cnt == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    xfer_cnt++;
                end
            end
        end
        if (reset_l && p_ovalid && p_oready) begin
            if (pq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL pad_unexpected_beat: got %0h expected none", p_beat);
            end else begin
                check("pad_beat", {p_first, p_last, p_beat}, pq.pop_front());
                p_xfer++;
            end
        end
    end

    // ---------------- o_ready driver ----------------
    int rdy_mode = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: o_ready = 1'b1;
            1: o_ready = (cyc % 3 == 0);
            2: o_ready = 1'($urandom_range(0, 1));
            default: o_ready = 1'b0;
        endcase
    end

    // ---------------- driver tasks ----------------
    task automatic accept_word(input logic [103:0] d);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!i_ready && n < 300);
        check("accept_timeout", i_ready, 1'b1);
        push_exp({24'h0, d}, 104, 0);
    endtask

    task automatic send_word(input logic [103:0] d);
        @(posedge clk); #1;
        i_valid = 1'b1;
        i_data  = d;
        accept_word(d);
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk); #2;
            n++;
        end while ((o_busy || exp_q.size() != 0) && n < 500);
        check("idle_timeout", {o_busy, 1'(exp_q.size() != 0)}, 2'b00);
    endtask

    typedef struct {
        logic [103:0] data;
        int           mode;
        int           exp_xfers;
    } vec_t;
    vec_t vecs[5];

    localparam logic [103:0] W0 = 104'h0C0B0A09080706050403020100;
    localparam logic [103:0] WF = {13{8'hFF}};

    initial begin
        vecs[0] = '{W0, 0, NT};
        vecs[1] = '{W0, 1, NT};
        vecs[2] = '{WF, 0, NT};
        vecs[3] = '{104'hDEAD_BEEF_0123_4567_89AB_CDEF_01, 2, NT};
        vecs[4] = '{104'h1, 1, NT};

        // reset state
        #2;
        check("rst_o_valid", o_valid, 1'b0);
        check("rst_o_first", o_first, 1'b0);
        check("rst_o_last", o_last, 1'b0);
        check("rst_o_busy", o_busy, 1'b0);
        check("rst_o_beat", o_beat, 8'h00);
        check("rst_i_ready", i_ready, 1'b1);
        repeat (3) @(posedge clk);
        #1 reset_l = 1'b1;

        // vector table
        for (int v = 0; v < 5; v++) begin
            rdy_mode = vecs[v].mode;
            xfer_cnt = 0;
            send_word(vecs[v].data);
            wait_idle();
            check("xfer_count", xfer_cnt, vecs[v].exp_xfers);
            check("busy_after", o_busy, 1'b0);
        end

        // back-to-back: B accepted on A's last-beat transfer, no gap
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        xfer_cnt = 0;
        #1;
        i_valid = 1'b1;
        i_data  = W0;
        accept_word(W0);
        @(posedge clk); #1;
        i_data = WF;
        accept_word(WF);
        check("b2b_ready_on_last", {o_last, o_ready}, 2'b11);
        @(posedge clk); #1;
        i_valid = 1'b0;
        wait_idle();
        check("b2b_xfers", xfer_cnt, 2 * NT);
        check("b2b_span", last_cyc - first_cyc + 1, 2 * NT);

        // blocked input while backpressured
        rdy_mode = 3;
        xfer_cnt = 0;
        send_word(W0);
        @(posedge clk); #1;
        i_valid = 1'b1;
        i_data  = WF;
        @(negedge clk);
        check("blk_i_ready", i_ready, 1'b0);
        check("blk_beat", {o_first, o_beat}, 9'h100);
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(negedge clk);
        check("blk_beat_held", {o_valid, o_first, o_beat}, 10'h300);
        rdy_mode = 0;
        wait_idle();
        check("blk_xfers", xfer_cnt, NT);

        // reset mid-word
        xfer_cnt = 0;
        send_word(W0);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk); #2;
            if (xfer_cnt >= 6) break;
        end
        check("mid_progress", xfer_cnt, 6);
        reset_l = 1'b0;
        #1;
        check("mid_rst_o_valid", o_valid, 1'b0);
        check("mid_rst_o_busy", o_busy, 1'b0);
        exp_q.delete();
        @(posedge clk); #1;
        reset_l = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {i_ready, o_valid}, 2'b10);
        xfer_cnt = 0;
        send_word(W0);
        wait_idle();
        check("post_rst_xfers", xfer_cnt, NT);

        // padding with WIDTH=105
        p_xfer = 0;
        @(posedge clk); #1;
        p_valid = 1'b1;
        p_data  = {1'b1, 104'h0};
        @(negedge clk);
        check("pad_accept", p_iready, 1'b1);
        push_exp({23'h0, 1'b1, 104'h0}, 105, 1);
        @(posedge clk); #1;
        p_valid = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk); #2;
            if (!p_busy) break;
        end
        check("pad_xfers", p_xfer, 14 + PAR);
        check("pad_queue_empty", pq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
